// File: rtl/freg_dump_streamer_if.sv
// Byte-stream handshake between the register dump streamer and its sink.
interface freg_dump_streamer_if;
    logic [7:0] oByte;
    logic       oByteValid;
    logic       iByteReady;

    modport master (output oByte, output oByteValid, input iByteReady);
    modport slave  (input oByte, input oByteValid, output iByteReady);
endinterface

// File: rtl/freg_dump_streamer.sv
// Streams a framed dump (header, then index + 4 data bytes per register, then checksum)
// of a contiguous, possibly wrapping, range of FP registers over a valid/ready byte link.
module freg_dump_streamer #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iStart,
    input  logic [4:0]           iFirst,
    input  logic [4:0]           iLast,
    output logic [4:0]           oRegSelect,
    input  logic [31:0]          iRegData,
    output logic                 oBusy,
    output logic                 oDone,
    freg_dump_streamer_if.master strm
);
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_IDX  = 3'd2,
        S_DATA = 3'd3,
        S_SUM  = 3'd4
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    sel_q;
    logic [IDX_W-1:0]    last_q;
    logic [BYTE_W-1:0]   byte_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   shadow_q;
    logic [BYTE_W-1:0]   cks_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                xfer;
    logic [BYTE_W-1:0]   cks_d;
    logic [IDX_W-1:0]    sel_d;
    logic [CNT_W-1:0]    cnt_d;

    assign xfer  = valid_q && strm.iByteReady;
    assign cks_d = cks_q + byte_q;
    assign sel_d = sel_q + IDX_W'(1);
    assign cnt_d = cnt_q + CNT_W'(1);

    // Shadow bytes leave MSB first.
    function automatic logic [BYTE_W-1:0] shadow_byte(input logic [DATA_W-1:0] w,
                                                      input logic [CNT_W-1:0]  c);
        case (c)
            2'd0:    shadow_byte = w[31:24];
            2'd1:    shadow_byte = w[23:16];
            2'd2:    shadow_byte = w[15:8];
            default: shadow_byte = w[7:0];
        endcase
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            last_q   <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shadow_q <= '0;
            cks_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        last_q  <= iLast;
                        sel_q   <= iFirst;
                        cks_q   <= '0;
                        byte_q  <= HEADER;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        byte_q  <= BYTE_W'(sel_q);
                        state_q <= S_IDX;
                    end
                end
                S_IDX: begin
                    // Register data is frozen here so later file writes cannot tear the frame.
                    if (xfer) begin
                        shadow_q <= iRegData;
                        cks_q    <= cks_d;
                        cnt_q    <= '0;
                        byte_q   <= shadow_byte(iRegData, CNT_W'(0));
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        cks_q <= cks_d;
                        if (cnt_q == CNT_W'(3)) begin
                            cnt_q <= '0;
                            if (sel_q == last_q) begin
                                byte_q  <= cks_d;
                                state_q <= S_SUM;
                            end else begin
                                sel_q   <= sel_d;
                                byte_q  <= BYTE_W'(sel_d);
                                state_q <= S_IDX;
                            end
                        end else begin
                            cnt_q  <= cnt_d;
                            byte_q <= shadow_byte(shadow_q, cnt_d);
                        end
                    end
                end
                S_SUM: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oRegSelect      = sel_q;
    assign oBusy           = busy_q;
    assign oDone           = done_q;
    assign strm.oByte      = byte_q;
    assign strm.oByteValid = valid_q;
endmodule

// File: tb/tb_freg_dump_streamer.sv
// Self-checking bench: randomized register contents and sink readiness compared against a
// frame-level reference model of the dump format.
module tb_freg_dump_streamer;
    localparam logic [7:0] HDR = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic [4:0]  sel;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];

    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    freg_dump_streamer_if sif ();

    assign rdata = regs[sel];

    freg_dump_streamer #(.HEADER(HDR)) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iStart     (start),
        .iFirst     (first),
        .iLast      (last),
        .oRegSelect (sel),
        .iRegData   (rdata),
        .oBusy      (busy),
        .oDone      (done),
        .strm       (sif)
    );

    // Reference frame: header, per register {index, 4 data bytes MSB first}, checksum.
    task automatic model_frame(input int f, input int l);
        int n;
        int idx;
        int sum;
        exp_q.delete();
        n = ((l - f + 32) % 32) + 1;
        sum = 0;
        exp_q.push_back(HDR);
        for (int k = 0; k < n; k++) begin
            idx = (f + k) % 32;
            exp_q.push_back(8'(idx));
            sum += idx;
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(8'(regs[idx] >> (8 * b)));
                sum += int'(8'(regs[idx] >> (8 * b)));
            end
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    // Starts a frame and records every transferred byte until oDone or the budget runs out.
    task automatic capture(input int f, input int l, input int rdy_pct,
                           input int stall_val, input int stall_n,
                           output bit done_seen, output int cycles, output int hold_bad);
        bit         prev_stall;
        logic [7:0] prev_byte;
        int         stalls;
        bit         rdy;
        got_q.delete();
        done_seen = 0; cycles = 0; hold_bad = 0; prev_stall = 0; prev_byte = '0; stalls = 0;
        @(negedge clk);
        first = 5'(f); last = 5'(l); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            cycles++;
            if (prev_stall && (!sif.oByteValid || sif.oByte !== prev_byte)) hold_bad++;
            if (done) begin
                done_seen = 1;
                break;
            end
            rdy = ($urandom_range(99) < rdy_pct);
            if (sif.oByteValid && int'(sif.oByte) == stall_val && stalls < stall_n) begin
                rdy = 1'b0;
                stalls++;
            end
            sif.iByteReady = rdy;
            if (sif.oByteValid && rdy) begin
                got_q.push_back(sif.oByte);
                prev_stall = 0;
            end else begin
                prev_stall = sif.oByteValid;
                prev_byte  = sif.oByte;
            end
            @(negedge clk);
        end
        sif.iByteReady = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({sel, sif.oByte, sif.oByteValid, busy, done} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state: got sel=%h byte=%h v=%b busy=%b done=%b, want all 0",
                     sel, sif.oByte, sif.oByteValid, busy, done);
        end
    endtask

    task automatic test_single();
        bit dn; int cyc; int hb;
        regs[3] = 32'h12345678;
        model_frame(3, 3);
        capture(3, 3, 100, -1, 0, dn, cyc, hb);
        n_cmp++;
        if (got_q.size() != 7 || exp_q.size() != 7) begin
            n_err++;
            $display("FAIL single_len: got %0d bytes, want 7", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL single_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (exp_q.size() == 7 && exp_q[6] !== 8'h17) begin
            n_err++;
            $display("FAIL single_model_sum: got %h want 17", exp_q[6]);
        end
        n_cmp++;
        if (!dn || cyc != 8) begin
            n_err++;
            $display("FAIL single_timing: done=%b cycles=%0d, want done=1 cycles=8", dn, cyc);
        end
        n_cmp++;
        if (busy !== 1'b0 || sif.oByteValid !== 1'b0 || sel !== 5'd3) begin
            n_err++;
            $display("FAIL single_idle: busy=%b valid=%b sel=%h, want 0 0 03", busy, sif.oByteValid, sel);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_width: got done=%b want 0", done);
        end
    endtask

    task automatic test_wrap();
        bit dn; int cyc; int hb;
        logic [7:0] want_idx [4];
        want_idx[0] = 8'h1E; want_idx[1] = 8'h1F; want_idx[2] = 8'h00; want_idx[3] = 8'h01;
        model_frame(30, 1);
        capture(30, 1, 100, -1, 0, dn, cyc, hb);
        n_cmp++;
        if (got_q.size() != 22 || !dn) begin
            n_err++;
            $display("FAIL wrap_len: got %0d bytes done=%b, want 22 done=1", got_q.size(), dn);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (got_q.size() > 1 + 5 * k && got_q[1 + 5 * k] !== want_idx[k]) begin
                n_err++;
                $display("FAIL wrap_idx%0d: got %h want %h", k, got_q[1 + 5 * k], want_idx[k]);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL wrap_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit dn; int cyc; int hb;
        regs[3] = 32'h12345678;
        model_frame(3, 3);
        capture(3, 3, 100, 8'h34, 3, dn, cyc, hb);
        n_cmp++;
        if (hb != 0 || !dn || cyc != 11) begin
            n_err++;
            $display("FAIL bp_hold: hold_errs=%0d done=%b cycles=%0d, want 0 1 11", hb, dn, cyc);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_coherence();
        int stage;
        bit dn;
        regs[3] = 32'h12345678;
        model_frame(3, 3);
        got_q.delete();
        stage = 0; dn = 0;
        sif.iByteReady = 1'b1;
        @(negedge clk);
        first = 5'd3; last = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                dn = 1;
                break;
            end
            if (stage == 1) begin
                regs[3] = 32'hFFFF_FFFF;
                start = 1'b1;
                first = 5'd7; last = 5'd9;
                stage = 2;
            end else if (stage == 2) begin
                start = 1'b0;
                stage = 3;
            end
            if (sif.oByteValid) begin
                if (stage == 0 && sif.oByte == 8'h03) stage = 1;
                got_q.push_back(sif.oByte);
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (!dn || got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL coh_len: done=%b got %0d bytes want %0d", dn, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL coh_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sif.oByteValid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL coh_no_restart: valid=%b busy=%b want 0 0", sif.oByteValid, busy);
            end
        end
        regs[3] = 32'h12345678;
    endtask

    task automatic test_reset_midframe();
        bit dn; int cyc; int hb; int seen;
        regs[3] = 32'h12345678;
        seen = 0;
        sif.iByteReady = 1'b1;
        @(negedge clk);
        first = 5'd3; last = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            if (sif.oByteValid) seen++;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({sel, sif.oByte, sif.oByteValid, busy, done} !== 16'h0) begin
            n_err++;
            $display("FAIL midframe_reset: got sel=%h byte=%h v=%b busy=%b done=%b, want all 0",
                     sel, sif.oByte, sif.oByteValid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sif.oByteValid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: valid=%b busy=%b want 0 0", sif.oByteValid, busy);
        end
        model_frame(3, 3);
        capture(3, 3, 100, -1, 0, dn, cyc, hb);
        n_cmp++;
        if (!dn || got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL restart_len: done=%b got %0d want %0d", dn, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL restart_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit dn; int cyc; int hb; int f; int l;
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 32; r++) regs[r] = $urandom;
            f = int'($urandom_range(31));
            l = (t == 0) ? f : int'($urandom_range(31));
            model_frame(f, l);
            capture(f, l, 55, -1, 0, dn, cyc, hb);
            n_cmp++;
            if (!dn || hb != 0 || got_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d_frame: done=%b hold_errs=%0d got %0d bytes want %0d",
                         t, dn, hb, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand%0d_byte%0d: got %h want %h", t, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first = '0; last = '0;
        sif.iByteReady = 1'b0;
        for (int r = 0; r < 32; r++) regs[r] = 32'(r) * 32'h0101_0101;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_single();
        test_wrap();
        test_backpressure();
        test_coherence();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/freg_dump_streamer.md
FREG_DUMP_STREAMER -- requirements
Module: freg_dump_streamer

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, first byte of every frame.
REQ-002 SHALL have port iCLK  input  1  clock, all state updates on posedge.
REQ-003 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iStart  input  1  frame request, sampled in IDLE only.
REQ-005 SHALL have port iFirst  input  5  first register index, captured on accepted start.
REQ-006 SHALL have port iLast  input  5  last register index, captured on accepted start.
REQ-007 SHALL have port oRegSelect  output  5  register index driven to the FP register file display read port.
REQ-008 SHALL have port iRegData  input  32  combinational register-file read data for oRegSelect, valid in the same cycle.
REQ-009 SHALL have port oByte  output  8  stream data byte.
REQ-010 SHALL have port oByteValid  output  1  stream byte valid.
REQ-011 SHALL have port iByteReady  input  1  sink ready; transfer = oByteValid && iByteReady at posedge.
REQ-012 SHALL have port oBusy  output  1  high in every state except IDLE.
REQ-013 SHALL have port oDone  output  1  one-cycle pulse on frame completion.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, IDX, DATA, SUM; all outputs registered.
REQ-015 IDLE: iStart=1 at posedge -> capture iFirst/iLast, oRegSelect<=iFirst, checksum<=0, go HDR; oByteValid=1, oByte=HEADER in the next cycle (1-cycle latency).
REQ-016 iStart SHALL be ignored in every state other than IDLE.
REQ-017 HDR: on transfer -> IDX, oByte={3'b000,oRegSelect}.
REQ-018 IDX: on transfer -> latch iRegData into 32-bit shadow register, add index byte to checksum, go DATA with byte counter 0.
REQ-019 DATA: oByte = shadow byte, MSB first (counter 0 -> bits 31:24 ... 3 -> bits 7:0); each transfer adds the byte to checksum and increments counter.
REQ-020 After the counter-3 transfer: if oRegSelect==last -> SUM, else oRegSelect<=oRegSelect+1 modulo 32 (31 wraps to 0), go IDX.
REQ-021 iFirst>iLast SHALL be a wrap-around range; register count N=((iLast-iFirst) mod 32)+1; first==last gives N=1.
REQ-022 SUM: oByte = 8-bit sum mod 256 of all index and data bytes (header excluded); on transfer -> IDLE, oByteValid<=0, oDone=1 for exactly the following cycle.
REQ-023 Frame SHALL be 2+5N bytes; with iByteReady held high, one byte per cycle, no bubbles.
REQ-024 While oByteValid=1 and iByteReady=0, oByte and all state SHALL hold unchanged; no byte lost or duplicated.
REQ-025 Data bytes SHALL come from the shadow only; iRegData changes after the IDX transfer SHALL NOT affect the frame.
REQ-026 oRegSelect SHALL retain its last value in IDLE.

Reset
REQ-027 iRST=1 SHALL immediately force IDLE, oRegSelect=0, oByte=0, oByteValid=0, oBusy=0, oDone=0, shadow=0, checksum=0, counter=0, from any state including mid-frame.
REQ-028 After reset release, the first accepted iStart SHALL begin a fresh frame with HEADER; no partial-frame resumption.

Verification
REQ-029 Reset: assert iRST mid-operation -> all outputs 0 same cycle, oBusy=0.
REQ-030 Single register: iFirst=iLast=3, reg3=32'h12345678, ready=1 -> bytes A5,03,12,34,56,78,17 on 7 consecutive cycles; oDone pulse in the cycle after 17.
REQ-031 Wrap range: iFirst=30, iLast=1 -> index bytes 1E,1F,00,01 in order, 22 bytes total, correct checksum.
REQ-032 Backpressure: ready low for 3 cycles while byte 0x34 is valid -> 0x34 held stable, then exactly one transfer; stream otherwise identical to REQ-030.
REQ-033 Coherence/start-ignore: change reg3 to 32'hFFFFFFFF one cycle after the IDX transfer and pulse iStart mid-frame -> data bytes still 12,34,56,78; no second frame.
REQ-034 Reset mid-frame after the 0x12 byte, release, iStart -> new frame begins A5,03,...; no leftover bytes.
